// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the word-serial multiword adder.
package multiword_add_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Word index width; a single-word operand still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/result bundle between a requester and the multiword adder sequencer.
interface multiword_add_seq_if #(
  parameter int unsigned W     = 3,
  parameter int unsigned WORDS = 2
);
  localparam int unsigned N = W * WORDS;

  logic         start;
  logic         sub;
  logic         cin;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, cin, op_a, op_b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, op_a, op_b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/rca_word.sv
// Combinational W-bit ripple-carry adder slice.
module rca_word #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = in1[i] ^ in2[i] ^ c;
      c      = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
    end
    carry = c;
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Adds/subtracts WORDS*W-bit operands one W-bit word per cycle, LSW first,
// through a single shared adder slice with a registered inter-word carry.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned WORDS = 2
) (
  input logic                clk,
  input logic                rst_n,
  multiword_add_seq_if.slave bus
);

  localparam int unsigned N    = W * WORDS;
  localparam int unsigned IdxW = idx_w(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;
  logic            done_q;

  logic [W-1:0]    a_word;
  logic [W-1:0]    b_word;
  logic [W-1:0]    slice_sum;
  logic            slice_carry;

  assign a_word = a_q[idx_q * W +: W];
  assign b_word = b_q[idx_q * W +: W];

  rca_word #(
    .W (W)
  ) u_rca_word (
    .in1   (a_word),
    .in2   (b_word),
    .cin   (carry_q),
    .sum   (slice_sum),
    .carry (slice_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.op_a;
            // Subtraction is A + ~B + 1; B is stored already inverted.
            b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_q <= bus.sub | bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[idx_q * W +: W] <= slice_sum;
          carry_q               <= slice_carry;
          if (idx_q == LastIdx) begin
            cout_q  <= slice_carry;
            ovf_q   <= (a_q[N-1] == b_q[N-1]) && (slice_sum[W-1] != a_q[N-1]);
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with W=3, WORDS=2 (6-bit operands).
module tb_multiword_add_seq;

  localparam int unsigned W     = 3;
  localparam int unsigned WORDS = 2;
  localparam int unsigned N     = W * WORDS;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  multiword_add_seq_if #(.W(W), .WORDS(WORDS)) bus ();

  multiword_add_seq #(
    .W     (W),
    .WORDS (WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic c);
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    bus.cin   = c;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic s, input logic c, input logic [N-1:0] e_sum,
                       input logic e_cout, input logic e_ovf);
    int cyc;
    launch(a, b, s, c);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'd2);
    chk({tag, "_sum"}, 64'(bus.sum), 64'(e_sum));
    chk({tag, "_cout"}, 64'(bus.cout), 64'(e_cout));
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'(e_ovf));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_sum_hold"}, 64'(bus.sum), 64'(e_sum));
  endtask

  initial begin
    int ndone;
    int first_d;
    int second_d;
    int cyc;
    n_chk     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 11 + 5 with intermediate-word checks: word0 = 011+101 -> 000, carry 1.
    launch(6'd11, 6'd5, 1'b0, 1'b0);
    chk("add1_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("add1_word0", 64'(bus.sum[2:0]), 64'd0);
    chk("add1_carry", 64'(dut.carry_q), 64'd1);
    chk("add1_nodone", 64'(bus.done), 64'd0);
    @(negedge clk);
    chk("add1_done", 64'(bus.done), 64'd1);
    chk("add1_busy_low", 64'(bus.busy), 64'd0);
    chk("add1_sum", 64'(bus.sum), 64'b010000);
    chk("add1_cout", 64'(bus.cout), 64'd0);
    chk("add1_ovf", 64'(bus.ovf), 64'd0);

    do_op("sub1", 6'd5, 6'd11, 1'b1, 1'b0, 6'b111010, 1'b0, 1'b0);
    do_op("wrap", 6'b111111, 6'b000001, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0);
    do_op("ovf", 6'b011111, 6'b000001, 1'b0, 1'b0, 6'b100000, 1'b0, 1'b1);
    do_op("cin", 6'd0, 6'd0, 1'b0, 1'b1, 6'b000001, 1'b0, 1'b0);
    // cin is ignored in subtract mode: 20 - 20 = 0, no borrow.
    do_op("subeq", 6'd20, 6'd20, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0);
    // -32 - 1 overflows: 100000 + 111110 + 1 -> 011111.
    do_op("subovf", 6'b100000, 6'd1, 1'b1, 1'b0, 6'b011111, 1'b1, 1'b1);

    // start pulsed again while busy with other operands must be ignored.
    launch(6'd11, 6'd5, 1'b0, 1'b0);
    bus.op_a  = 6'd1;
    bus.op_b  = 6'd1;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_sum", 64'(bus.sum), 64'b010000);

    // start held high: operations every WORDS+1 = 3 cycles.
    @(negedge clk);
    bus.op_a  = 6'd3;
    bus.op_b  = 6'd4;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    ndone     = 0;
    first_d   = -1;
    second_d  = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (ndone == 0) first_d = i;
        else if (ndone == 1) second_d = i;
        ndone++;
      end
    end
    bus.start = 1'b0;
    chk("held_ndone", 64'(ndone), 64'd3);
    chk("held_first", 64'(first_d), 64'd2);
    chk("held_gap", 64'(second_d - first_d), 64'd3);
    wait_done(cyc);
    chk("held_drain", 64'(bus.done), 64'd1);
    chk("held_sum", 64'(bus.sum), 64'd7);

    // Asynchronous reset mid-operation: partial word visible, then cleared at once.
    launch(6'd1, 6'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_mid_partial", 64'(bus.sum), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_sum", 64'(bus.sum), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("rst_mid_nodone", 64'(ndone), 64'd0);
    do_op("post_rst", 6'd2, 6'd3, 1'b0, 1'b0, 6'd5, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
